// File: rtl/wb_unified_mem_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encodings, grant bit positions, full byte-select mask.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Imported by wb_unified_mem_arbiter and its watchdog.
package wb_unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_t;

    localparam int         GNT_I_BIT  = 0;
    localparam int         GNT_D_BIT  = 1;
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        logic [1:0] g;
        g = '0;
        case (s)
            ARB_GNT_I: g[GNT_I_BIT] = 1'b1;
            ARB_GNT_D: g[GNT_D_BIT] = 1'b1;
            default:   g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_unified_mem_arbiter_watchdog.sv
// Per-transfer watchdog: counts granted cycles and expires on the TIMEOUT_CYCLES-th; 0 disables it.
// Latency: expire is combinational from the count. Backpressure: none, cleared while the arbiter idles.
// The counter saturates at its last value, so it never wraps into a false expiry.
module wb_unified_mem_arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// Shares one Wishbone slave between ibus and dbus, one transfer per grant; ARB_ROUND_ROBIN_EN selects round-robin.
// Latency: 1 arbitration cycle, then slave latency; responses are routed back with zero added latency.
// Backpressure: the loser keeps requesting and is re-arbitrated from IDLE; a watchdog errs out hung transfers.
module wb_unified_mem_arbiter
    import wb_unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_adr_i,
    input  logic              i_cyc_i,
    input  logic              i_stb_i,
    output logic [DATA_W-1:0] i_dat_o,
    output logic              i_ack_o,
    output logic              i_err_o,
    input  logic [ADDR_W-1:0] d_adr_i,
    input  logic [DATA_W-1:0] d_dat_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_sel_i,
    input  logic              d_cyc_i,
    input  logic              d_stb_i,
    output logic [DATA_W-1:0] d_dat_o,
    output logic              d_ack_o,
    output logic              d_err_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    output logic [1:0]        grant_o
);

    arb_state_t r_state;
    logic [1:0] r_grant;
    logic w_i_req, w_d_req, w_pick_d, w_granted;
    logic w_own_cyc, w_own_stb, w_expire, w_timeout, w_done, w_ack, w_err;

    assign w_i_req   = i_cyc_i & i_stb_i;
    assign w_d_req   = d_cyc_i & d_stb_i;
    assign w_granted = (r_state != ARB_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    // r_last_d: 1 when dbus owned the most recent grant, whatever its outcome.
    logic r_last_d;
    assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (w_granted && w_done) begin
            r_last_d <= (r_state == ARB_GNT_D);
        end
    end
`else
    assign w_pick_d = w_d_req;
`endif

    wb_unified_mem_arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (~w_granted),
        .i_en     (w_granted),
        .o_expire (w_expire)
    );

    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        case (r_state)
            ARB_GNT_I: begin
                s_adr_o   = i_adr_i;
                s_sel_o   = WB_SEL_ALL;
                w_own_cyc = i_cyc_i;
                w_own_stb = i_stb_i;
            end
            ARB_GNT_D: begin
                s_adr_o   = d_adr_i;
                s_dat_o   = d_dat_i;
                s_we_o    = d_we_i;
                s_sel_o   = d_sel_i;
                w_own_cyc = d_cyc_i;
                w_own_stb = d_stb_i;
            end
            default: ;
        endcase
    end

    // A slave response in the expiry cycle wins over the watchdog.
    assign w_timeout = w_expire & ~s_ack_i & ~s_err_i;
    assign w_ack     = w_own_cyc & s_ack_i & ~s_err_i;
    assign w_err     = w_own_cyc & (s_err_i | w_timeout);
    assign w_done    = s_ack_i | s_err_i | w_expire | ~w_own_cyc;

    assign s_cyc_o = w_own_cyc & ~w_timeout;
    assign s_stb_o = w_own_stb & ~w_timeout;

    assign i_ack_o = (r_state == ARB_GNT_I) & w_ack;
    assign i_err_o = (r_state == ARB_GNT_I) & w_err;
    assign i_dat_o = (r_state == ARB_GNT_I) ? s_dat_i : '0;
    assign d_ack_o = (r_state == ARB_GNT_D) & w_ack;
    assign d_err_o = (r_state == ARB_GNT_D) & w_err;
    assign d_dat_o = (r_state == ARB_GNT_D) ? s_dat_i : '0;
    assign grant_o = r_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_d) begin
                        r_state <= ARB_GNT_D;
                        r_grant <= grant_of(ARB_GNT_D);
                    end else if (w_i_req) begin
                        r_state <= ARB_GNT_I;
                        r_grant <= grant_of(ARB_GNT_I);
                    end
                end
                default: begin
                    if (w_done) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                    end
                end
            endcase
        end
    end

endmodule
